mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the instruction-fetch requester (IF) and the data-memory requester (DM) of the pipelined MIPS core.
- Serialises accesses with a small FSM and wait-state counter, and returns read data with one-cycle acks.
- Raises `stall` so the pipeline freezes until every pending request has been acknowledged.
- Sits between the `ifu`/`dm` request sides and the physical memory macro.

---
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and data memory requesters
module mem_port_arbiter #(
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  input  logic [3:0]  dm_be_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_ack_o,
  output logic        stall_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic [31:0] mem_rdata_i
);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  localparam logic [0:0] IDLE = 1'b0, ACCESS = 1'b1;
  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          grant_q, grant_d, last_q, last_d;
  logic          if_ack_q, if_ack_d, dm_ack_q, dm_ack_d;
  logic [31:0]   if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic          if_m, dm_m, pick_dm;
  // a requester whose ack is showing still holds req for the finished transaction
  assign if_m    = if_req_i & ~if_ack_q;
  assign dm_m    = dm_req_i & ~dm_ack_q;
  assign pick_dm = dm_m & (~if_m | ~last_q);
  assign stall_o = if_m | dm_m;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    last_d      = last_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if (state_q == IDLE) begin
      if (if_m | dm_m) begin
        state_d     = ACCESS;
        cnt_d       = CNT_INIT;
        grant_d     = pick_dm;
        last_d      = pick_dm;
        mem_en_d    = 1'b1;
        mem_we_d    = pick_dm & dm_we_i;
        mem_addr_d  = pick_dm ? dm_addr_i : if_addr_i;
        mem_wdata_d = pick_dm ? dm_wdata_i : '0;
        mem_be_d    = pick_dm ? dm_be_i : 4'hf;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      state_d    = IDLE;
      mem_en_d   = 1'b0;
      mem_we_d   = 1'b0;
      if_ack_d   = ~grant_q;
      dm_ack_d   = grant_q;
      if_rdata_d = ~grant_q ? mem_rdata_i : if_rdata_q;
      dm_rdata_d = (grant_q & ~mem_we_q) ? mem_rdata_i : dm_rdata_q;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      grant_q     <= 1'b0;
      last_q      <= 1'b0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end
  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_be_o    = mem_be_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of the arbiter against a transaction-timing model
module tb_mem_port_arbiter;
  localparam int LAT = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst_n, if_req, dm_req, dm_we, if_ack, dm_ack, stall, mem_en, mem_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  dm_be, mem_be;
  logic        if_req1, dm_req1, if_ack1, dm_ack1, stall1, mem_en1, mem_we1;
  logic [31:0] if_addr1, dm_addr1, if_rdata1, dm_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic [3:0]  mem_be1;
  logic [31:0] mem [0:255];
  assign mem_rdata  = mem[mem_addr[7:0]];
  assign mem_rdata1 = mem[mem_addr1[7:0]];
  mem_port_arbiter #(.LATENCY(LAT)) u0 (
    .clk_i(clk), .reset_ni(rst_n), .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata),
    .if_ack_o(if_ack), .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_be_i(dm_be), .dm_rdata_o(dm_rdata), .dm_ack_o(dm_ack), .stall_o(stall), .mem_en_o(mem_en),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
    .mem_rdata_i(mem_rdata));
  mem_port_arbiter #(.LATENCY(1)) u1 (
    .clk_i(clk), .reset_ni(rst_n), .if_req_i(if_req1), .if_addr_i(if_addr1), .if_rdata_o(if_rdata1),
    .if_ack_o(if_ack1), .dm_req_i(dm_req1), .dm_we_i(1'b0), .dm_addr_i(dm_addr1), .dm_wdata_i(32'h0),
    .dm_be_i(4'hf), .dm_rdata_o(dm_rdata1), .dm_ack_o(dm_ack1), .stall_o(stall1), .mem_en_o(mem_en1),
    .mem_we_o(mem_we1), .mem_addr_o(mem_addr1), .mem_wdata_o(mem_wdata1), .mem_be_o(mem_be1),
    .mem_rdata_i(mem_rdata1));
  int passed = 0, total = 0, cyc = 0;
  // model: one outstanding access, started at edge m_start and finished at edge m_start+LAT
  bit          m_busy, m_who, m_last, m_we, m_if_ack, m_dm_ack;
  int          m_start;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
  logic [3:0]  m_be;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, o, e);
  endtask
  task automatic predict();
    bit mi, md;
    cyc++;
    if (!rst_n) begin
      {m_busy, m_last, m_we, m_if_ack, m_dm_ack} = '0;
      {m_addr, m_wdata, m_if_rdata, m_dm_rdata, m_be} = '0;
      return;
    end
    mi = if_req && !m_if_ack;
    md = dm_req && !m_dm_ack;
    m_if_ack = 0;
    m_dm_ack = 0;
    if (m_busy) begin
      if (cyc == m_start + LAT) begin
        m_busy = 0;
        if (m_who) m_dm_ack = 1; else m_if_ack = 1;
        if (!m_we) begin
          if (m_who) m_dm_rdata = mem[m_addr[7:0]]; else m_if_rdata = mem[m_addr[7:0]];
        end else
          for (int b = 0; b < 4; b++) if (m_be[b]) mem[m_addr[7:0]][8*b +: 8] = m_wdata[8*b +: 8];
      end
    end else if (mi || md) begin
      m_who   = md && (!mi || !m_last);
      m_last  = m_who;
      m_busy  = 1;
      m_start = cyc;
      m_we    = m_who && dm_we;
      m_addr  = m_who ? dm_addr : if_addr;
      m_wdata = m_who ? dm_wdata : 32'h0;
      m_be    = m_who ? dm_be : 4'hf;
    end
  endtask
  task automatic tick();
    predict();
    @(negedge clk);
    chk("if_ack", if_ack, m_if_ack);
    chk("dm_ack", dm_ack, m_dm_ack);
    chk("stall", stall, (if_req && !m_if_ack) || (dm_req && !m_dm_ack));
    chk("mem_en", mem_en, m_busy);
    chk("mem_we", mem_we, m_busy && m_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("mem_be", mem_be, m_be);
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("dm_rdata", dm_rdata, m_dm_rdata);
  endtask
  initial begin
    int n, k, en_cnt, dm_t, if_t, acks;
    int t[4];
    logic [3:0] order;
    logic [31:0] old;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h40] = 32'h8C010004;
    {if_req, dm_req, dm_we, if_req1, dm_req1} = '0;
    {if_addr, dm_addr, dm_wdata, if_addr1, dm_addr1} = '0;
    dm_be = 4'h0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    // basic IF read
    if_req = 1; if_addr = 32'h40; n = 0;
    do begin tick(); n++; end while (!if_ack && n < 10);
    chk("t1_latency", n, 3);
    chk("t1_rdata", if_rdata, 32'h8C010004);
    if_req = 0;
    tick();
    // simultaneous requests right after reset: DM wins the tie
    rst_n = 0; tick(); rst_n = 1;
    if_req = 1; if_addr = 32'h44; dm_req = 1; dm_we = 0; dm_addr = 32'h100;
    dm_t = -100; if_t = -50;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (dm_ack) begin dm_t = cyc; dm_req = 0; end
      if (if_ack) begin if_t = cyc; if_req = 0; end
    end
    chk("t2_dm_to_if", if_t - dm_t, LAT + 1);
    // sustained contention
    if_req = 1; dm_req = 1; acks = 0; order = '0; k = 0;
    while (acks < 4 && k < 60) begin
      tick(); k++;
      if (dm_ack || if_ack) begin
        t[acks] = cyc; acks++;
        order = {order[2:0], dm_ack};
        if_addr = $urandom_range(0, 63); dm_addr = $urandom_range(0, 63);
        if (acks == 4) begin if_req = 0; dm_req = 0; end
      end
    end
    chk("t3_acks", acks, 4);
    chk("t3_order", order, 4'b1010);
    chk("t3_period", t[3] - t[0], 3 * (LAT + 1));
    tick(); tick();
    // DM write keeps dm_rdata
    old = mem[0];
    dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF; dm_be = 4'b0011; n = 0;
    do begin tick(); n++; end while (!dm_ack && n < 10);
    chk("t4_latency", n, 3);
    dm_req = 0; dm_we = 0;
    if_req = 1; if_addr = 32'h100; n = 0;
    do begin tick(); n++; end while (!if_ack && n < 10);
    chk("t4_readback", if_rdata, {old[31:16], 16'hBEEF});
    if_req = 0;
    tick();
    // reset in first access cycle abandons the access
    dm_req = 1; dm_addr = 32'h20;
    tick();
    chk("t5_access", mem_en, 1);
    rst_n = 0;
    tick();
    chk("t5_abort", mem_en, 0);
    rst_n = 1; n = 0;
    do begin tick(); n++; end while (!dm_ack && n < 10);
    chk("t5_latency", n, 3);
    chk("t5_rdata", dm_rdata, mem[8'h20]);
    dm_req = 0;
    tick();
    // LATENCY=1 instance
    if_req1 = 1; if_addr1 = 32'h0; n = 0; en_cnt = 0;
    do begin @(negedge clk); n++; en_cnt += int'(mem_en1); end while (!if_ack1 && n < 10);
    chk("t6_latency", n, 2);
    chk("t6_en_cycles", en_cnt, 1);
    chk("t6_rdata", if_rdata1, mem[0]);
    if_req1 = 0;
    @(negedge clk);
    if_req1 = 1; dm_req1 = 1; dm_addr1 = 32'h8; acks = 0; k = 0;
    while (acks < 4 && k < 40) begin
      @(negedge clk); k++;
      if (if_ack1 || dm_ack1) begin t[acks] = k; acks++; end
    end
    chk("t6_acks", acks, 4);
    chk("t6_period", t[3] - t[0], 6);
    if_req1 = 0; dm_req1 = 0;
    // random traffic
    for (int i = 0; i < 400; i++) begin
      tick();
      if (if_req ? if_ack : ($urandom_range(0, 2) == 0)) begin
        if_req  = if_req ? 1'($urandom_range(0, 1)) : 1'b1;
        if_addr = $urandom_range(0, 63);
      end
      if (dm_req ? dm_ack : ($urandom_range(0, 2) == 0)) begin
        dm_req   = dm_req ? 1'($urandom_range(0, 1)) : 1'b1;
        dm_we    = 1'($urandom_range(0, 1));
        dm_addr  = $urandom_range(0, 63);
        dm_wdata = $urandom;
        dm_be    = 4'($urandom_range(0, 15));
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
